// File: rtl/seg7_pkg.sv
// Shared glyphs, digit indices, display record and handshake states
// for the seven-segment scan driver and its BCD conversion engine.
package seg7_pkg;

  typedef enum logic [7:0] {
    SEG_0     = 8'hC0,
    SEG_1     = 8'hF9,
    SEG_2     = 8'hA4,
    SEG_3     = 8'hB0,
    SEG_4     = 8'h99,
    SEG_5     = 8'h92,
    SEG_6     = 8'h82,
    SEG_7     = 8'hF8,
    SEG_8     = 8'h80,
    SEG_9     = 8'h90,
    SEG_E     = 8'h86,
    SEG_MINUS = 8'hBF
  } segment_t;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  localparam logic [1:0] DIGIT_UNITS    = 2'd0;
  localparam logic [1:0] DIGIT_TENS     = 2'd1;
  localparam logic [1:0] DIGIT_HUNDREDS = 2'd2;
  localparam logic [1:0] DIGIT_SIGN     = 2'd3;

  localparam int MAX_DISPLAY = 999;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CONV,
    ST_ERR,
    ST_DONE
  } state_t;

  typedef struct packed {
    logic       err;
    logic       neg;
    logic [3:0] hund;
    logic [3:0] tens;
    logic [3:0] units;
  } disp_t;

  function automatic logic [7:0] glyph(input logic [3:0] d);
    case (d)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/seg7_scan_driver_bin2bcd_seq.sv
// Sequential double-dabble: one load cycle, then WIDTH shift-add-3
// cycles; done_o pulses with the final BCD digits and overflow flag.
module bin2bcd_seq
  import seg7_pkg::*;
#(
  parameter int WIDTH = 10
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start_i,
  input  logic [WIDTH:0] mag_i,
  output logic           busy_o,
  output logic           done_o,
  output logic [3:0]     hund_o,
  output logic [3:0]     tens_o,
  output logic [3:0]     units_o,
  output logic           ovf_o
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] sr_q;
  logic [11:0]      bcd_q;
  logic [11:0]      bcd_adj;
  logic [CW-1:0]    cnt_q;
  logic             busy_q;
  logic             done_q;
  logic             ovf_q;

  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 3; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5)
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q   <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start_i && !busy_q) begin
        sr_q   <= mag_i[WIDTH-1:0];
        bcd_q  <= '0;
        cnt_q  <= '0;
        busy_q <= 1'b1;
        ovf_q  <= 32'(mag_i) > 32'(MAX_DISPLAY);
      end else if (busy_q) begin
        {bcd_q, sr_q} <= {bcd_adj, sr_q} << 1;
        cnt_q         <= cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign busy_o  = busy_q;
  assign done_o  = done_q;
  assign hund_o  = bcd_q[11:8];
  assign tens_o  = bcd_q[7:4];
  assign units_o = bcd_q[3:0];
  assign ovf_o   = ovf_q;

endmodule

// File: rtl/seg7_scan_driver.sv
// 4-digit multiplexed seven-segment driver for a signed result.
// Define SEG7_LEADING_ZERO_BLANK_EN to blank leading zeros and filler.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int VALUE_WIDTH   = 10,
  parameter int ANODE_WIDTH   = 4,
  parameter int SEGMENT_WIDTH = 8,
  parameter int REFRESH_DIV   = 2500
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [VALUE_WIDTH-1:0]   value_i,
  input  logic                     error_i,
  input  logic                     load_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic [ANODE_WIDTH-1:0]   anodes,
  output logic [SEGMENT_WIDTH-1:0] segments
);

  localparam int MW = VALUE_WIDTH + 1;
  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  state_t               state_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 pend_q;
  logic [VALUE_WIDTH-1:0] pend_val_q;
  logic                 pend_err_q;
  logic                 neg_q;
  disp_t                disp_q;

  logic [RW-1:0]              ref_q;
  logic [1:0]                 idx_q;
  logic [ANODE_WIDTH-1:0]     anodes_q;
  logic [SEGMENT_WIDTH-1:0]   seg_q;
  logic [SEGMENT_WIDTH-1:0]   seg_d;
  logic                       ref_wrap;

  logic                   go;
  logic                   use_pend;
  logic [VALUE_WIDTH-1:0] src_val;
  logic                   src_err;
  logic                   src_neg;
  logic [MW-1:0]          src_ext;
  logic [MW-1:0]          src_mag;
  logic                   capture;

  logic       eng_start;
  logic       eng_busy;
  logic       eng_done;
  logic       eng_ovf;
  logic [3:0] eng_hund;
  logic [3:0] eng_tens;
  logic [3:0] eng_units;

  // A finished conversion hands over to the pending slot, or straight
  // to a load arriving in the same cycle, without an idle gap.
  always_comb begin
    go       = 1'b0;
    use_pend = 1'b0;
    src_val  = value_i;
    src_err  = error_i;
    if (state_q == ST_IDLE) begin
      go = load_i;
    end else if (state_q == ST_DONE) begin
      use_pend = pend_q;
      go       = pend_q || load_i;
      if (pend_q) begin
        src_val = pend_val_q;
        src_err = pend_err_q;
      end
    end
  end

  assign src_neg   = src_val[VALUE_WIDTH-1];
  assign src_ext   = {src_neg, src_val};
  assign src_mag   = src_neg ? -src_ext : src_ext;
  assign eng_start = go && !src_err && !eng_busy;
  assign capture   = load_i && busy_q && !(go && !use_pend);

  bin2bcd_seq #(
    .WIDTH (VALUE_WIDTH)
  ) u_bcd (
    .clk     (clk),
    .rst     (rst),
    .start_i (eng_start),
    .mag_i   (src_mag),
    .busy_o  (eng_busy),
    .done_o  (eng_done),
    .hund_o  (eng_hund),
    .tens_o  (eng_tens),
    .units_o (eng_units),
    .ovf_o   (eng_ovf)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pend_q     <= 1'b0;
      pend_val_q <= '0;
      pend_err_q <= 1'b0;
      neg_q      <= 1'b0;
      disp_q     <= '0;
    end else begin
      done_q <= 1'b0;
      if (go) begin
        state_q <= src_err ? ST_ERR : ST_CONV;
        busy_q  <= 1'b1;
        neg_q   <= src_neg;
        if (use_pend)
          pend_q <= 1'b0;
      end else begin
        unique case (state_q)
          ST_IDLE: ;
          ST_CONV: begin
            if (eng_done) begin
              disp_q  <= '{err:   eng_ovf,
                           neg:   neg_q,
                           hund:  eng_hund,
                           tens:  eng_tens,
                           units: eng_units};
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end
          end
          ST_ERR: begin
            disp_q  <= '{1'b1, 1'b0, 4'd0, 4'd0, 4'd0};
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end
          ST_DONE: begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        endcase
      end
      if (capture) begin
        pend_q     <= 1'b1;
        pend_val_q <= value_i;
        pend_err_q <= error_i;
      end
    end
  end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  localparam logic [7:0] FILL    = SEG_BLANK;
  localparam logic [7:0] POS_SGN = SEG_BLANK;
  logic blank_h;
  logic blank_t;
  assign blank_h = disp_q.hund == 4'd0;
  assign blank_t = blank_h && disp_q.tens == 4'd0;
`else
  localparam logic [7:0] FILL    = SEG_0;
  localparam logic [7:0] POS_SGN = SEG_0;
  logic blank_h;
  logic blank_t;
  assign blank_h = 1'b0;
  assign blank_t = 1'b0;
`endif

  always_comb begin
    seg_d = SEG_BLANK;
    if (disp_q.err) begin
      seg_d = (idx_q == DIGIT_UNITS) ? SEG_E : FILL;
    end else begin
      unique case (idx_q)
        DIGIT_UNITS:    seg_d = glyph(disp_q.units);
        DIGIT_TENS:     seg_d = blank_t ? SEG_BLANK : glyph(disp_q.tens);
        DIGIT_HUNDREDS: seg_d = blank_h ? SEG_BLANK : glyph(disp_q.hund);
        DIGIT_SIGN:     seg_d = disp_q.neg ? SEG_MINUS : POS_SGN;
      endcase
    end
  end

  assign ref_wrap = ref_q == RW'(REFRESH_DIV - 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      ref_q    <= '0;
      idx_q    <= '0;
      anodes_q <= '1;
      seg_q    <= SEG_BLANK;
    end else begin
      ref_q <= ref_wrap ? '0 : ref_q + RW'(1);
      if (ref_wrap)
        idx_q <= idx_q + 2'd1;
      anodes_q <= ~(ANODE_WIDTH'(1) << idx_q);
      seg_q    <= seg_d;
    end
  end

  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign anodes   = anodes_q;
  assign segments = seg_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench: timestamped handshake model feeds expected displays;
// a negedge monitor checks the scan, segments and done timing.
`timescale 1ns/1ps
module tb_seg7_scan_driver;

  localparam int VW  = 10;
  localparam int RD  = 4;
  localparam int LAT = VW + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [VW-1:0] value_i = '0;
  logic          error_i = 1'b0;
  logic          load_i = 1'b0;
  logic          busy_o;
  logic          done_o;
  logic [3:0]    anodes;
  logic [7:0]    segments;

  seg7_scan_driver #(
    .VALUE_WIDTH   (VW),
    .ANODE_WIDTH   (4),
    .SEGMENT_WIDTH (8),
    .REFRESH_DIV   (RD)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .value_i  (value_i),
    .error_i  (error_i),
    .load_i   (load_i),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .anodes   (anodes),
    .segments (segments)
  );

  always #5 clk = ~clk;

  typedef struct {
    int              lat;
    int              done_edge;
    logic [3:0][7:0] seg;
  } exp_t;

  logic [7:0] GL [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                          8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
`ifdef SEG7_LEADING_ZERO_BLANK_EN
  localparam logic [7:0] FILLV = 8'hFF;
`else
  localparam logic [7:0] FILLV = 8'hC0;
`endif

  exp_t            sbq[$];
  int              checks = 0;
  int              failures = 0;
  int              cyc = 0;
  int              rst_edge = 0;
  logic [3:0][7:0] shown;
  int              cur_start = -100;
  int              cur_done = -100;
  bit              has_pend = 0;
  exp_t            pend;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) rst_edge <= cyc + 1;
  end

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at edge %0d",
               name, act, exp, cyc);
    end
  endtask

  function automatic logic [3:0][7:0] model_disp(bit err, logic [VW-1:0] val);
    int v;
    int m;
    logic [3:0][7:0] s;
    v = $signed(val);
    m = (v < 0) ? -v : v;
    if (err || m > 999) begin
      s[0] = 8'h86;
      s[1] = FILLV;
      s[2] = FILLV;
      s[3] = FILLV;
    end else begin
      s[0] = GL[m % 10];
      s[1] = GL[(m / 10) % 10];
      s[2] = GL[m / 100];
      s[3] = (v < 0) ? 8'hBF : 8'hC0;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
      if (m < 100) s[2] = 8'hFF;
      if (m < 10) s[1] = 8'hFF;
      if (v >= 0) s[3] = 8'hFF;
`endif
    end
    return s;
  endfunction

  task automatic start_item(exp_t it, int e);
    it.done_edge = e + it.lat;
    cur_start = e;
    cur_done = it.done_edge;
    sbq.push_back(it);
  endtask

  // One clock: apply inputs, advance the timestamp model, check busy_o.
  task automatic tick(bit ld, bit er, logic [VW-1:0] v);
    int e;
    exp_t it;
    load_i = ld;
    error_i = er;
    value_i = v;
    e = cyc + 1;
    if (!rst) begin
      it.lat = er ? 1 : LAT;
      it.seg = model_disp(er, v);
      it.done_edge = 0;
      if (e == cur_done + 1 && has_pend) begin
        start_item(pend, e);
        has_pend = 0;
        if (ld) begin
          pend = it;
          has_pend = 1;
        end
      end else if (ld && e > cur_done) begin
        start_item(it, e);
      end else if (ld) begin
        pend = it;
        has_pend = 1;
      end
    end
    @(posedge clk);
    #1;
    check("busy_o", {31'd0, busy_o},
          (cyc >= cur_start && cyc <= cur_done) ? 1 : 0);
    load_i = 1'b0;
    error_i = 1'b0;
  endtask

  task automatic idle(int n);
    repeat (n) tick(1'b0, 1'b0, '0);
  endtask

  task automatic do_reset(int n);
    rst = 1'b1;
    sbq.delete();
    has_pend = 0;
    cur_start = -100;
    cur_done = -100;
    idle(n);
    rst = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((cyc <= cur_done || has_pend) && n < 200) begin
      idle(1);
      n++;
    end
    check("idle_reached", {31'd0, n < 200}, 1);
  endtask

  initial begin : monitor
    exp_t mit;
    int   mk;
    int   md;
    forever begin
      @(negedge clk);
      if (cyc > 0) begin
        if (cyc == rst_edge) begin
          check("reset_out", {anodes, segments, busy_o, done_o},
                {4'hF, 8'hFF, 1'b0, 1'b0});
          shown = model_disp(1'b0, '0);
        end else begin
          mk = cyc - rst_edge;
          md = ((mk - 1) / RD) % 4;
          check("scan", {anodes, segments}, {~(4'b0001 << md), shown[md]});
          if (done_o) begin
            if (sbq.size() == 0) begin
              check("unexpected_done", 1, 0);
            end else begin
              mit = sbq.pop_front();
              check("done_time", cyc, mit.done_edge);
              check("busy_at_done", {31'd0, busy_o}, 1);
              shown = mit.seg;
            end
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin : driver
    logic [VW-1:0] rv;
    bit            re;
    do_reset(3);
    idle(20);

    tick(1'b1, 1'b0, VW'(225));
    wait_idle();
    idle(18);

    tick(1'b1, 1'b0, VW'(-15));
    wait_idle();
    idle(18);

    tick(1'b1, 1'b0, VW'(-512));
    wait_idle();
    idle(18);

    tick(1'b1, 1'b0, VW'(7));
    tick(1'b1, 1'b1, '0);
    wait_idle();
    idle(18);

    tick(1'b1, 1'b0, VW'(3));
    tick(1'b1, 1'b0, VW'(4));
    tick(1'b1, 1'b0, VW'(5));
    wait_idle();
    idle(18);

    tick(1'b1, 1'b0, '0);
    wait_idle();
    idle(18);

    repeat (60) begin
      rv = VW'($urandom);
      re = ($urandom_range(0, 9) == 0);
      tick(1'b1, re, rv);
      idle($urandom_range(0, 14));
    end
    wait_idle();
    idle(18);

    tick(1'b1, 1'b0, VW'(500));
    idle(4);
    do_reset(2);
    idle(20);

    tick(1'b1, 1'b0, VW'(5));
    wait_idle();
    idle(18);

    check("queue_empty", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
